// File: rtl/fall_monitor_pkg.sv
// ---------------------------------------------------------------------------
// fall_monitor_pkg
//   Shared types and helpers for the multi-channel fall monitor.
//   - fall_state_t : per-channel FSM state (IDLE, PENDING, ALARM)
//   - belowRelease : widened "sample + hyst < threshold" compare that cannot wrap
// ---------------------------------------------------------------------------
package fall_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    ALARM   = 2'd2
  } fall_state_t;

  // Operand width for the release compare; channel widths up to this are supported.
  localparam int CALC_W = 32;

  // Operands are zero-extended by one bit before the add, so a sample near
  // full scale plus the hysteresis margin can never wrap and look "low".
  // A threshold at or below the margin therefore never releases.
  function automatic logic belowRelease(input logic [CALC_W-1:0] sampleVal,
                                        input logic [CALC_W-1:0] thresholdVal,
                                        input logic [CALC_W-1:0] hystVal);
    logic [CALC_W:0] sum;
    sum = {1'b0, sampleVal} + {1'b0, hystVal};
    return sum < {1'b0, thresholdVal};
  endfunction

endpackage

// File: rtl/fall_monitor_channel.sv
// ---------------------------------------------------------------------------
// fall_channel
//   One independent fall-detection channel: persistence counter, FSM and
//   acknowledge memory.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     sampleValid  : sample/threshold are evaluated only when high
//     sample       : channel sample (unsigned)
//     threshold    : channel fall threshold (unsigned, read live)
//     ack          : alarm acknowledge (pulse or level)
//     nextAlarm    : combinational next-state alarm (feeds top-level any/first)
//     alarm        : registered latched alarm
//     alarmEvent   : registered one-cycle pulse on entry into ALARM
//     state        : current FSM state (debug visibility)
//
// Handshake: there is no back-pressure. sampleValid is a one-sided strobe;
// every cycle it is high the channel consumes the sample, otherwise the
// state and counter hold. ack is level-sensitive and only remembered in ALARM.
// ---------------------------------------------------------------------------
module fall_channel
  import fall_monitor_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PERSIST = 3,
  parameter int HYST    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sampleValid,
  input  logic [WIDTH-1:0] sample,
  input  logic [WIDTH-1:0] threshold,
  input  logic             ack,
  output logic             nextAlarm,
  output logic             alarm,
  output logic             alarmEvent,
  output fall_state_t      state
);

  localparam int             CW      = $clog2(PERSIST + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(PERSIST);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);

  fall_state_t   stateQ, stateD;
  logic [CW-1:0] cntQ, cntD;
  logic          ackSeenQ, ackSeenD;
  logic          enterAlarm;
  logic          qualify;
  logic          relOk;

  assign qualify = (sample >= threshold);
  assign relOk   = belowRelease(CALC_W'(sample), CALC_W'(threshold), CALC_W'(HYST));

  always_comb begin
    stateD     = stateQ;
    cntD       = cntQ;
    ackSeenD   = ackSeenQ;
    enterAlarm = 1'b0;
    case (stateQ)
      IDLE: begin
        ackSeenD = 1'b0;
        if (sampleValid && qualify) begin
          cntD = CNT_ONE;
          if (PERSIST == 1) begin
            stateD     = ALARM;
            enterAlarm = 1'b1;
          end else begin
            stateD = PENDING;
          end
        end
      end
      PENDING: begin
        ackSeenD = 1'b0;
        if (sampleValid) begin
          if (qualify) begin
            // Saturating increment; reaching PERSIST moves to ALARM.
            if (cntQ != CNT_MAX) cntD = cntQ + CNT_ONE;
            if (cntD == CNT_MAX) begin
              stateD     = ALARM;
              enterAlarm = 1'b1;
            end
          end else begin
            stateD = IDLE;
            cntD   = '0;
          end
        end
      end
      ALARM: begin
        if (ack) ackSeenD = 1'b1;
        // An ack in the same cycle as the release sample is enough.
        if (sampleValid && relOk && (ackSeenQ || ack)) begin
          stateD   = IDLE;
          cntD     = '0;
          ackSeenD = 1'b0;
        end
      end
      default: begin
        stateD   = IDLE;
        cntD     = '0;
        ackSeenD = 1'b0;
      end
    endcase
  end

  assign nextAlarm = (stateD == ALARM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ     <= IDLE;
      cntQ       <= '0;
      ackSeenQ   <= 1'b0;
      alarm      <= 1'b0;
      alarmEvent <= 1'b0;
    end else begin
      stateQ     <= stateD;
      cntQ       <= cntD;
      ackSeenQ   <= ackSeenD;
      alarm      <= nextAlarm;
      alarmEvent <= enterAlarm;
    end
  end

  assign state = stateQ;

endmodule

// File: rtl/fall_monitor.sv
// ---------------------------------------------------------------------------
// fall_monitor
//   Multi-channel fall detector. Each channel raises a latched alarm after
//   PERSIST consecutive valid samples at or above its threshold, and releases
//   only after acknowledge plus a sample below threshold - HYST.
//   Ports:
//     clk, rst_n     : clock, asynchronous active-low reset
//     sample_valid   : qualifies all channel samples this cycle
//     sample         : N_CH packed samples, channel i at [i*WIDTH +: WIDTH]
//     factory_value  : N_CH packed thresholds, same packing
//     ack            : per-channel acknowledge
//     fall_detected  : latched alarm per channel (registered)
//     fall_event     : one-cycle pulse on ALARM entry (registered)
//     any_fall       : OR of alarms (registered from next-state)
//     first_ch       : lowest-index alarmed channel, 0 when none (registered)
//     dbgState       : per-channel FSM state, 2 bits per channel
// ---------------------------------------------------------------------------
module fall_monitor
  import fall_monitor_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int N_CH    = 4,
  parameter int PERSIST = 3,
  parameter int HYST    = 4,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_valid,
  input  logic [N_CH*WIDTH-1:0] sample,
  input  logic [N_CH*WIDTH-1:0] factory_value,
  input  logic [N_CH-1:0]       ack,
  output logic [N_CH-1:0]       fall_detected,
  output logic [N_CH-1:0]       fall_event,
  output logic                  any_fall,
  output logic [CH_W-1:0]       first_ch,
  output logic [2*N_CH-1:0]     dbgState
);

  logic [N_CH-1:0] nextAlarm;
  logic [CH_W-1:0] firstD;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    fall_state_t chState;

    fall_channel #(
      .WIDTH   (WIDTH),
      .PERSIST (PERSIST),
      .HYST    (HYST)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .sampleValid (sample_valid),
      .sample      (sample[i*WIDTH +: WIDTH]),
      .threshold   (factory_value[i*WIDTH +: WIDTH]),
      .ack         (ack[i]),
      .nextAlarm   (nextAlarm[i]),
      .alarm       (fall_detected[i]),
      .alarmEvent  (fall_event[i]),
      .state       (chState)
    );

    assign dbgState[2*i +: 2] = chState;
  end

  // Lowest index wins: scan from the top so lower channels overwrite.
  always_comb begin
    firstD = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (nextAlarm[i]) firstD = CH_W'(i);
    end
  end

  // Built from next-state alarms so these align with fall_detected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_fall <= 1'b0;
      first_ch <= '0;
    end else begin
      any_fall <= |nextAlarm;
      first_ch <= firstD;
    end
  end

endmodule

// File: tb/tb_fall_monitor.sv
module tb_fall_monitor;

  localparam int WIDTH   = 8;
  localparam int N_CH    = 2;
  localparam int PERSIST = 3;
  localparam int HYST    = 4;
  localparam int EXP_W   = 2 * N_CH + 2;

  // ---------------- clock / reset / DUT ----------------
  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  sample_valid = 1'b0;
  logic [N_CH*WIDTH-1:0] sample = '0;
  logic [N_CH*WIDTH-1:0] factory_value = '0;
  logic [N_CH-1:0]       ack = '0;
  logic [N_CH-1:0]       fall_detected;
  logic [N_CH-1:0]       fall_event;
  logic                  any_fall;
  logic [0:0]            first_ch;
  logic [2*N_CH-1:0]     dbgState;

  always #5 clk = ~clk;

  fall_monitor #(
    .WIDTH   (WIDTH),
    .N_CH    (N_CH),
    .PERSIST (PERSIST),
    .HYST    (HYST)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_valid  (sample_valid),
    .sample        (sample),
    .factory_value (factory_value),
    .ack           (ack),
    .fall_detected (fall_detected),
    .fall_event    (fall_event),
    .any_fall      (any_fall),
    .first_ch      (first_ch),
    .dbgState      (dbgState)
  );

  // ---------------- counters / check ----------------
  int nCompared   = 0;
  int nMismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkOut(input string name, input logic [1:0] det, input logic [1:0] evt,
                          input logic any, input logic first);
    check({name, "/fall_detected"}, 32'(fall_detected), 32'(det));
    check({name, "/fall_event"},    32'(fall_event),    32'(evt));
    check({name, "/any_fall"},      32'(any_fall),      32'(any));
    check({name, "/first_ch"},      32'(first_ch),      32'(first));
  endtask

  // ---------------- behavioural model / scoreboard ----------------
  // Each channel is tracked as "length of current qualifying run" plus
  // "alarm raised" plus "ack remembered while alarmed".
  int                run[N_CH];
  bit                alarmed[N_CH];
  bit                ackMem[N_CH];
  logic [N_CH-1:0]   mEvt, mDet;
  logic              mFirst;
  logic [EXP_W-1:0]  expVec = '0;
  logic [EXP_W-1:0]  exp_q[$];

  always @(posedge clk or negedge rst_n) begin : model
    int s, t;
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        run[i] = 0; alarmed[i] = 0; ackMem[i] = 0;
      end
      expVec = '0;
      exp_q.delete();
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        s = int'(sample[i*WIDTH +: WIDTH]);
        t = int'(factory_value[i*WIDTH +: WIDTH]);
        mEvt[i] = 1'b0;
        if (alarmed[i]) begin
          if (sample_valid && (s + HYST < t) && (ackMem[i] || ack[i])) begin
            alarmed[i] = 0; ackMem[i] = 0; run[i] = 0;
          end else if (ack[i]) begin
            ackMem[i] = 1;
          end
        end else if (sample_valid) begin
          if (s >= t) run[i] = run[i] + 1;
          else        run[i] = 0;
          if (run[i] >= PERSIST) begin
            alarmed[i] = 1;
            mEvt[i]    = 1'b1;
          end
        end
        mDet[i] = alarmed[i];
      end
      mFirst = 1'b0;
      for (int i = N_CH - 1; i >= 0; i--) if (alarmed[i]) mFirst = 1'(i);
      expVec = {mEvt, mDet, |mDet, mFirst};
      exp_q.push_back(expVec);
    end
  end

  always @(negedge clk) begin : compare
    logic [EXP_W-1:0] e;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    else                   e = expVec;
    check("cyc/fall_event",    32'(fall_event),    32'(e[5:4]));
    check("cyc/fall_detected", 32'(fall_detected), 32'(e[3:2]));
    check("cyc/any_fall",      32'(any_fall),      32'(e[1]));
    check("cyc/first_ch",      32'(first_ch),      32'(e[0]));
  end

  // ---------------- driver ----------------
  task automatic step(input logic v, input int s0, input int s1, input logic [1:0] a);
    @(negedge clk);
    #1;
    sample_valid = v;
    sample       = {s1[7:0], s0[7:0]};
    ack          = a;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    ack          = '0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    factory_value = {8'd200, 8'd100};
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOut("reset", 2'b00, 2'b00, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Persistence: 100,120,101
    step(1, 100, 0, 2'b00);
    step(1, 120, 0, 2'b00);
    checkOut("persist_2", 2'b00, 2'b00, 1'b0, 1'b0);
    step(1, 101, 0, 2'b00);
    checkOut("persist_3", 2'b01, 2'b01, 1'b1, 1'b0);
    step(0, 0, 0, 2'b00);
    checkOut("persist_hold", 2'b01, 2'b00, 1'b1, 1'b0);

    // Hysteresis + ack
    step(1, 97, 0, 2'b00);
    checkOut("hyst_97_noack", 2'b01, 2'b00, 1'b1, 1'b0);
    step(0, 0, 0, 2'b01);
    step(1, 96, 0, 2'b00);
    checkOut("hyst_96", 2'b01, 2'b00, 1'b1, 1'b0);
    step(1, 95, 0, 2'b00);
    checkOut("hyst_95", 2'b00, 2'b00, 1'b0, 1'b0);

    // Broken run: 100,99,100,100 then 100
    step(1, 100, 0, 2'b00);
    step(1, 99,  0, 2'b00);
    step(1, 100, 0, 2'b00);
    step(1, 100, 0, 2'b00);
    checkOut("broken_4", 2'b00, 2'b00, 1'b0, 1'b0);
    step(1, 100, 0, 2'b00);
    checkOut("broken_5", 2'b01, 2'b01, 1'b1, 1'b0);
    step(1, 50, 0, 2'b01);
    checkOut("broken_rel", 2'b00, 2'b00, 1'b0, 1'b0);

    // Gaps between qualifying samples
    step(1, 100, 0, 2'b00);
    step(0, 0,   0, 2'b00);
    step(0, 0,   0, 2'b00);
    step(1, 100, 0, 2'b00);
    step(0, 0,   0, 2'b00);
    checkOut("gap_2", 2'b00, 2'b00, 1'b0, 1'b0);
    step(1, 100, 0, 2'b00);
    checkOut("gap_3", 2'b01, 2'b01, 1'b1, 1'b0);
    step(1, 50, 0, 2'b01);
    checkOut("gap_rel", 2'b00, 2'b00, 1'b0, 1'b0);

    // Ack during PENDING is not remembered
    step(1, 100, 0, 2'b01);
    step(1, 100, 0, 2'b01);
    step(1, 100, 0, 2'b00);
    checkOut("pend_ack_alarm", 2'b01, 2'b01, 1'b1, 1'b0);
    step(1, 50, 0, 2'b00);
    checkOut("pend_ack_stale", 2'b01, 2'b00, 1'b1, 1'b0);
    step(1, 50, 0, 2'b01);
    checkOut("pend_ack_fresh", 2'b00, 2'b00, 1'b0, 1'b0);

    // Multi-channel, ch1 threshold 3 (at or below HYST: never releases)
    factory_value = {8'd3, 8'd100};
    step(1, 100, 3, 2'b00);
    step(1, 100, 5, 2'b00);
    step(1, 100, 3, 2'b00);
    checkOut("multi_both", 2'b11, 2'b11, 1'b1, 1'b0);
    step(1, 50, 0, 2'b11);
    checkOut("multi_ch0_rel", 2'b10, 2'b00, 1'b1, 1'b1);
    step(1, 0, 0, 2'b11);
    checkOut("multi_ch1_stuck", 2'b10, 2'b00, 1'b1, 1'b1);

    // Async reset with ch0 mid-PENDING and ch1 in ALARM
    step(1, 100, 0, 2'b00);
    step(1, 100, 0, 2'b00);
    #2;
    rst_n = 1'b0;
    #1;
    checkOut("async_reset", 2'b00, 2'b00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    factory_value = {8'd200, 8'd100};
    step(1, 100, 0, 2'b00);
    step(1, 100, 0, 2'b00);
    checkOut("post_reset_2", 2'b00, 2'b00, 1'b0, 1'b0);
    step(1, 100, 0, 2'b00);
    checkOut("post_reset_3", 2'b01, 2'b01, 1'b1, 1'b0);

    repeat (2) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/fall_monitor.md
# fall_monitor

Multi-channel, parametrised fall detector. Each channel compares a sensor sample against its factory threshold. A fall is declared only after `PERSIST` consecutive qualifying samples. Once declared, the alarm is latched until it is acknowledged and the sample has dropped below the threshold minus a hysteresis margin. It sits between the sensor sampling front end and the alarm/indicator logic, and replaces the single-channel combinational fall comparator.

## Interface
- `WIDTH`, 8: sample and threshold width in bits.
- `N_CH`, 4: number of independent channels (≥1).
- `PERSIST`, 3: consecutive qualifying samples needed to raise an alarm (≥1).
- `HYST`, 4: release hysteresis, in LSBs.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sample_valid`  in  1  qualifies all channel samples this cycle.
- `sample`  in  N_CH*WIDTH  channel i sample at `[i*WIDTH +: WIDTH]`, unsigned.
- `factory_value`  in  N_CH*WIDTH  per-channel fall threshold, unsigned, same packing.
- `ack`  in  N_CH  per-channel alarm acknowledge (pulse or level).
- `fall_detected`  out  N_CH  latched alarm per channel.
- `fall_event`  out  N_CH  one-cycle pulse when a channel enters ALARM.
- `any_fall`  out  1  OR of `fall_detected`.
- `first_ch`  out  max(1,$clog2(N_CH))  lowest-index channel in ALARM; 0 when none.

## Operation
- Qualify: `sample >= factory_value` (greater-or-equal counts as a fall).
- Release: `sample + HYST < factory_value`, computed in WIDTH+1 bits with no wrap. If `factory_value <= HYST`, the channel never releases; only reset clears it.
- A channel only evaluates samples in cycles where `sample_valid`=1. Otherwise its state and counter hold.
- The threshold is read live each valid cycle, so a threshold change takes effect on the next valid sample.
- Per-channel FSM:
  - IDLE: a qualifying sample sets the counter to 1. If PERSIST=1 the channel goes to ALARM; otherwise it goes to PENDING.
  - PENDING: a qualifying sample increments the counter, and the channel goes to ALARM when the counter reaches PERSIST. A non-qualifying sample returns the channel to IDLE and clears the counter.
  - ALARM: an `ack`=1 in any cycle sets `ack_seen`. The channel returns to IDLE on a valid release sample with (`ack_seen` or `ack`) true, and `ack_seen` is cleared on exit. A qualifying or in-band sample keeps the alarm.
- `ack` in IDLE or PENDING is ignored and not remembered.
- Counter width is `$clog2(PERSIST+1)`. It saturates and never wraps.
- Channels are fully independent. Simultaneous events on several channels are each handled in the same cycle.

## Timing
- Reset values: state IDLE, counter 0, `ack_seen` 0, and all outputs 0 (`fall_detected`, `fall_event`, `any_fall`, `first_ch`).
- All outputs are registered.
- `fall_detected[i]` and `fall_event[i]` rise on the clock edge that samples the PERSIST-th consecutive qualifying valid sample, so latency is 1 cycle from that sample.
- `fall_event[i]` is high for exactly one cycle per IDLE/PENDING→ALARM entry.
- `fall_detected[i]` falls on the edge that samples the releasing valid sample.
- `any_fall` and `first_ch` are updated on the same edge as `fall_detected`, from next-state values, so they never lag.
- Asserting `rst_n` mid-operation forces all state and outputs to reset values immediately, without waiting for a clock. Release from reset is synchronous to `clk`, and the first evaluation happens on the first valid cycle after release.

## Structure
- Package `fall_monitor_pkg`:
  - state enum `fall_state_t` {IDLE, PENDING, ALARM}
  - helper function for the WIDTH+1-bit release compare.
- Sub-module `fall_channel`: one FSM, counter and `ack_seen` per channel, instantiated N_CH times via generate.
- The top level holds only the packing/unpacking, the `any_fall` OR-reduce and the lowest-index priority encoder for `first_ch`.

## Test plan
All scenarios use WIDTH=8, N_CH=2, PERSIST=3, HYST=4, and threshold ch0=100.
- **Persistence:** ch0 valid samples 100,120,101 → `fall_event[0]` one-cycle pulse after the third sample, and `fall_detected[0]`=1, `any_fall`=1, `first_ch`=0.
- **Broken run:** ch0 samples 100,99,100,100 → no alarm. Then one more 100 → alarm after that fifth sample.
- **Hysteresis + ack:** ch0 in ALARM.
  - Sample 97 with no ack → stays in ALARM.
  - `ack` pulse, then sample 96 → stays (96+4 = 100, not below 100).
  - Sample 95 → `fall_detected[0]` clears.
- **Gaps and ack ordering:**
  - Qualifying samples separated by `sample_valid`=0 cycles → the count is preserved and the alarm fires after the 3rd valid one.
  - `ack` given while PENDING → ignored; after the alarm, release requires a fresh ack.
- **Multi-channel / edge threshold:**
  - ch1 threshold=3 and ch0=100; both alarm in the same cycle → `first_ch`=0.
  - After ch0 releases, `first_ch`=1.
  - ch1 never releases, even on sample 0 with ack.
- **Async reset:** `rst_n` low mid-PENDING and mid-ALARM → all outputs 0 without a clock edge; after release, 3 fresh qualifying samples are needed.
